fifo_stream_reader: RTL and testbench

- Drain engine for the team's synchronous FIFO (registered read data, 1-cycle read latency, empty flag).
- Pops words from the FIFO and presents them on a valid/ready output stream. Absorbs downstream backpressure with a 2-entry output buffer.
- Frames the stream into bursts of BurstLen beats and marks the final beat with m_last.
- Sits between the FIFO read port and any stream consumer (packetizer, bus master).

---
 rtl/fifo_pkg.sv | 12 +
 rtl/fifo_stream_reader_skid_buf2.sv | 80 ++++++++
 rtl/fifo_stream_reader.sv | 92 +++++++++
 tb/tb_fifo_stream_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the sync FIFO and its stream reader.
package fifo_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } reader_state_e;

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry valid/ready buffer of {data, last}; entry 0 is always the head.
module stream_skid_buf2 #(
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DataWidth-1:0] wr_data,
  input  logic                 wr_last,
  input  logic                 rd_en,
  output logic [DataWidth-1:0] rd_data,
  output logic                 rd_last,
  output logic [1:0]           occ
);

  logic [DataWidth-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                 last0_q, last0_d, last1_q, last1_d;
  logic [1:0]           occ_q, occ_d;
  logic                 pop;

  always_comb begin
    data0_d = data0_q;
    data1_d = data1_q;
    last0_d = last0_q;
    last1_d = last1_q;
    occ_d   = occ_q;
    pop     = rd_en && (occ_q != 2'd0);
    case ({wr_en, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = wr_data;
          last0_d = wr_last;
        end else begin
          data1_d = wr_data;
          last1_d = wr_last;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        // head leaves and the new word lands behind whatever remains
        if (occ_q == 2'd1) begin
          data0_d = wr_data;
          last0_d = wr_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = wr_data;
          last1_d = wr_last;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      occ_q   <= 2'd0;
    end else begin
      data0_q <= data0_d;
      data1_q <= data1_d;
      last0_q <= last0_d;
      last1_q <= last1_d;
      occ_q   <= occ_d;
    end
  end

  assign rd_data = data0_q;
  assign rd_last = last0_q;
  assign occ     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains the sync FIFO into a valid/ready stream framed in bursts of BurstLen beats.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH,
  parameter int unsigned BurstLen  = 16,
  parameter int unsigned CntWidth  = $clog2(BurstLen + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DataWidth-1:0] fifo_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 m_last,
  output logic                 busy
);

  localparam logic [CntWidth-1:0] LastCnt = CntWidth'(BurstLen - 1);

  reader_state_e        state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 inflight_last_q, inflight_last_d;
  logic [1:0]           buf_occ;
  logic [2:0]           credit_used;
  logic                 hs, is_last, at_boundary_stop, pop;

  always_comb begin
    hs               = m_valid && m_ready;
    // slots still committed after this cycle's handshake frees one
    credit_used      = 3'(buf_occ) + 3'(inflight_q) - 3'(hs);
    is_last          = (cnt_q == LastCnt);
    at_boundary_stop = !enable && (cnt_q == '0);
    pop              = (state_q == RUN) && !fifo_empty && (credit_used < 3'd2) &&
                       !at_boundary_stop;

    cnt_d           = cnt_q;
    inflight_d      = pop;
    inflight_last_d = pop && is_last;
    state_d         = state_q;

    if (pop) begin
      cnt_d = is_last ? '0 : cnt_q + CntWidth'(1);
    end

    case (state_q)
      IDLE:  if (enable) state_d = RUN;
      RUN: begin
        if (at_boundary_stop || (pop && is_last && !enable)) state_d = DRAIN;
      end
      DRAIN: if ((buf_occ == 2'd0) && !inflight_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  stream_skid_buf2 #(
    .DataWidth(DataWidth)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (inflight_q),
    .wr_data(fifo_data),
    .wr_last(inflight_last_q),
    .rd_en  (m_ready),
    .rd_data(m_data),
    .rd_last(m_last),
    .occ    (buf_occ)
  );

  assign fifo_rd_en = pop;
  assign m_valid    = (buf_occ != 2'd0);
  assign busy       = (state_q != IDLE) || (buf_occ != 2'd0) || inflight_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: two readers (BurstLen 16 and 1) fed by behavioural sync FIFOs, checked by a scoreboard.
module tb_fifo_stream_reader;
  import fifo_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable[2], fifo_empty[2], fifo_rd_en[2], m_valid[2], m_ready[2], m_last[2], busy[2];
  logic [31:0] fifo_data[2], m_data[2];

  logic [31:0] fmem[2][256];
  logic [7:0]  fwp[2], frp[2];
  logic        push_en[2];
  logic [31:0] push_data[2];

  logic [31:0] exp_mem[2][256];
  int          exp_wr[2], exp_rd[2], beat[2], hs_count[2];
  int          hs_cyc[2][256];
  logic        prev_stall[2], prev_last[2];
  logic [31:0] prev_data[2];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_stream_reader #(.DataWidth(32), .BurstLen(16)) dut_a (
    .clk(clk), .rst(rst), .enable(enable[0]), .fifo_empty(fifo_empty[0]),
    .fifo_rd_en(fifo_rd_en[0]), .fifo_data(fifo_data[0]), .m_valid(m_valid[0]),
    .m_ready(m_ready[0]), .m_data(m_data[0]), .m_last(m_last[0]), .busy(busy[0])
  );

  fifo_stream_reader #(.DataWidth(32), .BurstLen(1)) dut_b (
    .clk(clk), .rst(rst), .enable(enable[1]), .fifo_empty(fifo_empty[1]),
    .fifo_rd_en(fifo_rd_en[1]), .fifo_data(fifo_data[1]), .m_valid(m_valid[1]),
    .m_ready(m_ready[1]), .m_data(m_data[1]), .m_last(m_last[1]), .busy(busy[1])
  );

  // behavioural sync FIFO: registered read data, one-cycle latency
  assign fifo_empty[0] = (fwp[0] == frp[0]);
  assign fifo_empty[1] = (fwp[1] == frp[1]);

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        fwp[i]       <= 8'd0;
        frp[i]       <= 8'd0;
        fifo_data[i] <= 32'd0;
      end else begin
        if (push_en[i]) begin
          fmem[i][fwp[i]] <= push_data[i];
          fwp[i]          <= fwp[i] + 8'd1;
        end
        if (fifo_rd_en[i] && !fifo_empty[i]) begin
          fifo_data[i] <= fmem[i][frp[i]];
          frp[i]       <= frp[i] + 8'd1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int bl(input int i);
    return (i == 0) ? 16 : 1;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        exp_rd[i]     = exp_wr[i];
        beat[i]       = 0;
        prev_stall[i] = 1'b0;
      end
    end else begin
      check("credit", 32'((32'(dut_a.buf_occ) + 32'(dut_a.inflight_q)) <= 2), 32'd1);
      for (int i = 0; i < 2; i++) begin
        check("rd_while_empty", 32'(fifo_rd_en[i] && fifo_empty[i]), 32'd0);
        if (prev_stall[i]) begin
          check("stall_valid", 32'(m_valid[i]), 32'd1);
          check("stall_data", m_data[i], prev_data[i]);
          check("stall_last", 32'(m_last[i]), 32'(prev_last[i]));
        end
        if (m_valid[i] && m_ready[i]) begin
          check("beat_expected", 32'(exp_rd[i] < exp_wr[i]), 32'd1);
          if (exp_rd[i] < exp_wr[i]) begin
            check("data", m_data[i], exp_mem[i][exp_rd[i]]);
            check("last", 32'(m_last[i]), 32'((beat[i] % bl(i)) == bl(i) - 1));
            exp_rd[i]++;
          end
          beat[i]++;
          hs_cyc[i][hs_count[i] & 255] = cyc;
          hs_count[i]++;
        end
        prev_stall[i] = m_valid[i] && !m_ready[i];
        prev_data[i]  = m_data[i];
        prev_last[i]  = m_last[i];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_words(input int i, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      push_en[i]             = 1'b1;
      push_data[i]           = 32'(first + k);
      exp_mem[i][exp_wr[i]]  = 32'(first + k);
      exp_wr[i]++;
    end
    @(posedge clk);
    #1;
    push_en[i] = 1'b0;
  endtask

  task automatic wait_hs(input int i, input int target, input int bound);
    int n = 0;
    while (hs_count[i] < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (hs_count[i] < target) check("timeout_hs", 32'(hs_count[i]), 32'(target));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    int n;
    for (int i = 0; i < 2; i++) begin
      enable[i] = 1'b0; m_ready[i] = 1'b1; push_en[i] = 1'b0; push_data[i] = 32'd0;
      exp_wr[i] = 0; exp_rd[i] = 0; beat[i] = 0; hs_count[i] = 0; prev_stall[i] = 1'b0;
    end
    rst = 1'b1;
    tick(3);
    @(negedge clk);
    check("rst_valid", 32'(m_valid[0]), 32'd0);
    check("rst_data", m_data[0], 32'd0);
    check("rst_last", 32'(m_last[0]), 32'd0);
    check("rst_busy", 32'(busy[0]), 32'd0);
    check("rst_rd_en", 32'(fifo_rd_en[0]), 32'd0);
    tick(1);
    rst = 1'b0;

    // burst 1: preload 0x1..0x10, full throughput
    push_words(0, 32'h1, 16);
    enable[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!fifo_rd_en[0] && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!m_valid[0] && n < 20) begin @(negedge clk); n++; end
    check("first_latency", 32'(cyc - t0), 32'd2);
    wait_hs(0, 16, 100);
    check("burst1_tput", 32'(hs_cyc[0][15] - hs_cyc[0][0]), 32'd15);

    // bursts 2-3 under 1,0,0,1 backpressure
    fork
      push_words(0, 32'h11, 32);
      begin
        int p = 0;
        int g = 0;
        while (hs_count[0] < 48 && g < 600) begin
          @(posedge clk);
          #1;
          m_ready[0] = (p % 4 == 0) || (p % 4 == 3);
          p++;
          g++;
        end
      end
    join
    m_ready[0] = 1'b1;
    wait_hs(0, 48, 100);

    // burst 4: FIFO runs dry after 5 words, refilled 10 cycles later
    push_words(0, 32'h31, 5);
    wait_hs(0, 53, 100);
    tick(3);
    @(negedge clk);
    check("gap_valid", 32'(m_valid[0]), 32'd0);
    check("gap_busy", 32'(busy[0]), 32'd1);
    tick(7);
    @(negedge clk);
    check("gap_valid_late", 32'(m_valid[0]), 32'd0);
    push_words(0, 32'h36, 11);
    wait_hs(0, 64, 200);

    // burst 5: enable dropped a few beats in, burst must complete
    fork
      push_words(0, 32'h41, 20);
      begin
        wait_hs(0, 67, 200);
        @(posedge clk);
        #1;
        enable[0] = 1'b0;
      end
    join
    n = 0;
    @(negedge clk);
    while (busy[0] && n < 200) begin @(negedge clk); n++; end
    check("drain_busy", 32'(busy[0]), 32'd0);
    check("drain_hs_count", 32'(hs_count[0]), 32'd80);
    check("drain_state", 32'(dut_a.state_q), 32'(IDLE));
    tick(5);
    @(negedge clk);
    check("drain_no_pop", 32'(fwp[0] - frp[0]), 32'd4);
    check("drain_rd_en", 32'(fifo_rd_en[0]), 32'd0);

    // reset with the output buffer full and the consumer stalled
    m_ready[0] = 1'b0;
    enable[0]  = 1'b1;
    tick(8);
    @(negedge clk);
    check("pre_rst_valid", 32'(m_valid[0]), 32'd1);
    check("pre_rst_head", m_data[0], 32'h51);
    check("pre_rst_occ", 32'(dut_a.buf_occ), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid[0]), 32'd0);
    check("mid_rst_busy", 32'(busy[0]), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en[0]), 32'd0);
    check("mid_rst_data", m_data[0], 32'd0);
    tick(1);
    rst = 1'b0;
    m_ready[0] = 1'b1;
    push_words(0, 32'h61, 16);
    wait_hs(0, 96, 200);
    enable[0] = 1'b0;

    // BurstLen = 1 instance
    push_words(1, 32'hB0, 8);
    enable[1] = 1'b1;
    wait_hs(1, 8, 100);
    check("bl1_tput", 32'(hs_cyc[1][7] - hs_cyc[1][0]), 32'd7);
    check("bl1_count", 32'(hs_count[1]), 32'd8);
    enable[1] = 1'b0;
    tick(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
